// File: rtl/flash_rd_seq.sv
// flash_rd_seq: polls flash WIP, then streams read bytes from x1spi through a 4-entry FIFO,
// splitting the read into several SPI transactions whenever the FIFO is close to full.
module flash_rd_seq #(
    parameter bit FAST_READ = 1'b1,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        done,
    output logic        err,
    input  logic        spi_ready,
    output logic        spi_start,
    output logic [7:0]  spi_cmd,
    output logic [23:0] spi_addr,
    output logic        spi_addr_en,
    output logic [2:0]  spi_dummy_num,
    output logic        spi_exist_rx,
    input  logic        spi_finish,
    input  logic [7:0]  spi_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_PSTART, S_PWAIT, S_PGAP, S_RSTART, S_RWAIT, S_DONE} state_t;
    state_t state, state_n;
    logic [23:0] cur_addr, cur_addr_n;
    logic [15:0] rem, rem_n, poll_cnt, poll_cnt_n, gap_cnt, gap_cnt_n;
    logic err_q, err_n, go, push, pop;
    logic [8:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt, cnt_n;
    assign pop = out_valid && out_ready;
    assign push = state == S_RWAIT && spi_finish;
    assign cnt_n = cnt + {2'b0, push} - {2'b0, pop};
    assign out_valid = cnt != 3'd0;
    assign {out_last, out_data} = out_valid ? mem[rd_ptr] : 9'd0;
    assign req_ready = state == S_IDLE;
    assign done = state == S_DONE && cnt == 3'd0;
    assign err = done && err_q;
    always_comb begin
        state_n = state;
        cur_addr_n = cur_addr;
        rem_n = rem;
        poll_cnt_n = poll_cnt;
        gap_cnt_n = gap_cnt;
        err_n = err_q;
        go = 1'b0;
        case (state)
            S_IDLE: if (req_valid) begin
                cur_addr_n = req_addr;
                rem_n = req_len;
                poll_cnt_n = '0;
                err_n = 1'b0;
                state_n = req_len == 16'd0 ? S_DONE : S_PSTART;
            end
            S_PSTART: if (spi_ready) begin
                go = 1'b1;
                state_n = S_PWAIT;
            end
            S_PWAIT: if (spi_finish) begin
                poll_cnt_n = poll_cnt + 16'd1;
                gap_cnt_n = '0;
                if (!spi_rdata[0]) state_n = S_RSTART;
                else if (poll_cnt_n == 16'(POLL_MAX)) begin
                    err_n = 1'b1;
                    state_n = S_DONE;
                end else state_n = S_PGAP;
            end
            S_PGAP: begin
                gap_cnt_n = gap_cnt + 16'd1;
                state_n = gap_cnt_n >= 16'(POLL_GAP) ? S_PSTART : S_PGAP;
            end
            // two free slots: one for the first byte, one of margin for the registered exist_rx
            S_RSTART: if (spi_ready && cnt <= 3'd2) begin
                go = 1'b1;
                state_n = S_RWAIT;
            end
            S_RWAIT: if (spi_finish) begin
                cur_addr_n = cur_addr + 24'd1;
                rem_n = rem - 16'd1;
                state_n = rem_n == 16'd0 ? S_DONE : (spi_exist_rx ? S_RWAIT : S_RSTART);
            end
            S_DONE: if (cnt == 3'd0) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cur_addr <= '0;
            rem <= '0;
            poll_cnt <= '0;
            gap_cnt <= '0;
            err_q <= 1'b0;
            spi_start <= 1'b0;
            spi_cmd <= '0;
            spi_addr <= '0;
            spi_addr_en <= 1'b0;
            spi_dummy_num <= '0;
            spi_exist_rx <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            cur_addr <= cur_addr_n;
            rem <= rem_n;
            poll_cnt <= poll_cnt_n;
            gap_cnt <= gap_cnt_n;
            err_q <= err_n;
            spi_start <= go;
            if (go) begin
                spi_cmd <= state == S_PSTART ? 8'h05 : (FAST_READ ? 8'h0B : 8'h03);
                spi_addr <= state == S_PSTART ? 24'd0 : cur_addr;
                spi_addr_en <= state != S_PSTART;
                spi_dummy_num <= (state != S_PSTART && FAST_READ) ? 3'd1 : 3'd0;
            end
            // the byte in flight still needs a slot, so continuing requires room for two more
            spi_exist_rx <= state_n == S_RWAIT && rem_n > 16'd1 && cnt_n <= 3'd1;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            cnt <= cnt_n;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {rem == 16'd1, spi_rdata};
    end
endmodule

// File: tb/tb_flash_rd_seq.sv
// tb_flash_rd_seq: directed bench for flash_rd_seq with a behavioural x1spi responder.
`timescale 1ns/1ps
module tb_flash_rd_seq;
    localparam int PMAX = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic out_valid, out_ready = 1'b1, out_last, done, err;
    logic [7:0] out_data;
    logic spi_ready = 1'b1, spi_start, spi_addr_en, spi_exist_rx, spi_finish = 1'b0;
    logic [7:0] spi_cmd, spi_rdata = '0;
    logic [23:0] spi_addr;
    logic [2:0] spi_dummy_num;
    int checks = 0, errors = 0;
    int polls = 0, reads = 0, rd_bytes = 0, done_cnt = 0, cyc = 0, last_fin = -1, min_gap = 1000;
    int busy_polls = 0, occ = 0;
    logic [7:0] busy_stat = 8'h01, rd_cmd = '0;
    logic [2:0] rd_dummy = '0;
    logic rd_aen = 1'b0, done_err = 1'b0, unstable = 1'b0, ovf = 1'b0, bad_start = 1'b0;
    logic [23:0] rd_addr [$];
    logic [7:0] rx_data [$];
    logic rx_last [$];
    logic [7:0] exp_b [16];

    flash_rd_seq #(.FAST_READ(1'b1), .POLL_MAX(PMAX), .POLL_GAP(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err),
        .spi_ready(spi_ready), .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_addr(spi_addr),
        .spi_addr_en(spi_addr_en), .spi_dummy_num(spi_dummy_num), .spi_exist_rx(spi_exist_rx),
        .spi_finish(spi_finish), .spi_rdata(spi_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fbyte(input logic [23:0] x);
        return x[7:0] + x[23:16] + 8'h3C;
    endfunction

    // x1spi model: samples mid-cycle, applies its registered response just after the next edge
    initial begin : x1spi
        bit busy, is_rd, st, ex, fin, rdy, fin_n, rdy_n;
        int tmr, endt;
        logic [7:0] cmd, rd_n;
        logic [23:0] a, ba;
        logic aen;
        logic [2:0] dn;
        busy = 0; is_rd = 0; tmr = 0; endt = 0; cmd = '0; a = '0; ba = '0; aen = 0; dn = '0;
        forever begin
            @(negedge clk);
            cyc++;
            st = spi_start; ex = spi_exist_rx; fin = spi_finish; rdy = spi_ready;
            if (out_valid && out_ready) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
            end
            if (done) begin
                done_cnt++;
                done_err = err;
            end
            if (busy && (spi_cmd !== cmd || spi_addr !== a || spi_addr_en !== aen || spi_dummy_num !== dn))
                unstable = 1'b1;
            if (fin && is_rd && occ >= 4) ovf = 1'b1;
            occ += ((fin && is_rd) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            if (st && !rdy) bad_start = 1'b1;
            fin_n = 0; rd_n = spi_rdata; rdy_n = rdy;
            if (st && rdy) begin
                busy = 1; cmd = spi_cmd; a = spi_addr; ba = spi_addr; aen = spi_addr_en; dn = spi_dummy_num;
                is_rd = spi_cmd != 8'h05;
                tmr = 8 + 4 * ((aen ? 3 : 0) + int'(dn));
                rdy_n = 0;
                if (is_rd) begin
                    reads++;
                    rd_addr.push_back(a);
                    rd_cmd = cmd; rd_dummy = dn; rd_aen = aen;
                end else begin
                    polls++;
                    if (last_fin >= 0 && cyc - last_fin - 1 < min_gap) min_gap = cyc - last_fin - 1;
                end
            end else if (fin) begin
                if (!is_rd) last_fin = cyc;
                if (ex) tmr = 8;
                else endt = 2;
            end else if (tmr > 0) begin
                tmr--;
                if (tmr == 0) begin
                    fin_n = 1;
                    rd_n = is_rd ? fbyte(ba) : (polls <= busy_polls ? busy_stat : 8'h00);
                    if (is_rd) begin
                        ba++;
                        rd_bytes++;
                    end
                end
            end else if (endt > 0) begin
                endt--;
                if (endt == 0) begin
                    rdy_n = 1;
                    busy = 0;
                end
            end
            @(posedge clk);
            #1;
            spi_finish = fin_n; spi_rdata = rd_n; spi_ready = rdy_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        polls = 0; reads = 0; rd_bytes = 0; done_cnt = 0; done_err = 1'b0;
        last_fin = -1; min_gap = 1000;
        rd_addr.delete(); rx_data.delete(); rx_last.delete();
    endtask

    task automatic send(input logic [23:0] a, input logic [15:0] l);
        int n = 0;
        @(posedge clk); #1;
        req_addr = a; req_len = l; req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, done_cnt, 1);
    endtask

    function automatic logic [23:0] raddr(input int i);
        return (i < rd_addr.size()) ? rd_addr[i] : 24'hBADBAD;
    endfunction

    task automatic chk_rx(input string tag, input int n, input logic [15:0] lastv);
        logic [15:0] lv = '0;
        chk({tag, "_count"}, rx_data.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), (i < rx_data.size()) ? {24'd0, rx_data[i]} : 32'hFFFFFFFF, {24'd0, exp_b[i]});
        for (int i = 0; i < rx_last.size() && i < 16; i++) lv[i] = rx_last[i];
        chk({tag, "_last"}, lv, lastv);
    endtask

    initial begin
        int s, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_exist_rx", spi_exist_rx, 0);
        chk("rst_spi_cmd", spi_cmd, 0);
        rst = 1'b0;

        // basic fast read of 4 bytes
        clr(); busy_polls = 0; out_ready = 1'b1;
        send(24'h001000, 16'd4);
        wait_done("t1_done");
        chk("t1_polls", polls, 1);
        chk("t1_reads", reads, 1);
        chk("t1_addr", raddr(0), 24'h001000);
        chk("t1_cmd", rd_cmd, 8'h0B);
        chk("t1_dummy", rd_dummy, 1);
        chk("t1_addr_en", rd_aen, 1);
        chk("t1_err", done_err, 0);
        for (int i = 0; i < 4; i++) exp_b[i] = 8'h3C + 8'(i);
        chk_rx("t1", 4, 16'h0008);

        // three busy polls, then ready
        clr(); busy_polls = 3; busy_stat = 8'h01;
        send(24'h002000, 16'd2);
        wait_done("t2_done");
        chk("t2_polls", polls, 4);
        chk("t2_gap_ge16", (min_gap >= 16) ? 16 : min_gap, 16);
        chk("t2_reads", reads, 1);
        chk("t2_err", done_err, 0);
        exp_b[0] = 8'h3C; exp_b[1] = 8'h3D;
        chk_rx("t2", 2, 16'h0002);

        // WIP stuck: timeout after POLL_MAX polls
        clr(); busy_polls = 100; busy_stat = 8'h03;
        send(24'h004000, 16'd8);
        wait_done("t3_done");
        chk("t3_polls", polls, PMAX);
        chk("t3_reads", reads, 0);
        chk("t3_rx", rx_data.size(), 0);
        chk("t3_err", done_err, 1);

        // backpressure: transaction stops after 3 bytes, resumes at the next address
        clr(); busy_polls = 0; out_ready = 1'b0;
        send(24'h001000, 16'd10);
        repeat (100) @(negedge clk);
        chk("t4_stall_reads", reads, 1);
        chk("t4_stall_bytes", rd_bytes, 3);
        chk("t4_stall_valid", out_valid, 1);
        chk("t4_stall_data", out_data, 8'h3C);
        out_ready = 1'b1;
        wait_done("t4_done");
        chk("t4_reads", reads, 2);
        chk("t4_resume_addr", raddr(1), 24'h001003);
        chk("t4_err", done_err, 0);
        for (int i = 0; i < 10; i++) exp_b[i] = 8'h3C + 8'(i);
        chk_rx("t4", 10, 16'h0200);

        // address wrap at a resumed read
        clr(); out_ready = 1'b0;
        send(24'hFFFFFD, 16'd4);
        repeat (100) @(negedge clk);
        chk("t5_stall_bytes", rd_bytes, 3);
        out_ready = 1'b1;
        wait_done("t5_done");
        chk("t5_reads", reads, 2);
        chk("t5_addr0", raddr(0), 24'hFFFFFD);
        chk("t5_resume_addr", raddr(1), 24'h000000);
        exp_b[0] = 8'h38; exp_b[1] = 8'h39; exp_b[2] = 8'h3A; exp_b[3] = 8'h3C;
        chk_rx("t5", 4, 16'h0008);

        // zero-length request
        clr();
        @(posedge clk); #1;
        req_addr = 24'h123456; req_len = 16'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t6_done", done, 1);
        chk("t6_err", err, 0);
        @(posedge clk); #1;
        chk("t6_done_drop", done, 0);
        chk("t6_req_ready", req_ready, 1);
        repeat (20) @(negedge clk);
        chk("t6_no_spi", polls + reads, 0);

        chk("spi_fields_stable", unstable, 0);
        chk("fifo_no_overflow", ovf, 0);
        chk("start_only_when_ready", bad_start, 0);

        // reset in the middle of a read
        clr(); out_ready = 1'b0;
        send(24'h003000, 16'd10);
        n = 0;
        while (rd_bytes < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t7_reached_read", rd_bytes >= 1, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t7_out_valid", out_valid, 0);
        chk("t7_req_ready", req_ready, 1);
        chk("t7_spi_start", spi_start, 0);
        rst = 1'b0; occ = 0;
        s = polls + reads;
        repeat (200) @(negedge clk);
        chk("t7_no_new_start", polls + reads, s);
        chk("t7_idle_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
